peecc_run_controller: RTL and testbench
=======================================

# peecc_run_controller

Sequencing controller that sits directly upstream of the encode/bus/decode datapath. It drives that datapath's stage enables (`en_gen_data`, `en_enc`, `en_bus`, `en_dec`, `en_trans_count`, `en_k_comp`) and its `done` strobe. It also collects the `isequal` check result every valid cycle and latches the final transition statistics (`max_reg`, `sum_transitions`) once a run of `NUM_WORDS` generated words has fully drained.

## Interface
- `NUM_WORDS`, default 1000: words generated per run; legal range 1..2047, bounded by the 11-bit histogram bins downstream.
- `CHECK_DELAY`, default 5: cycles from a word's `en_gen_data` cycle to the cycle its `isequal` is valid.
- `ERR_W`, default 16: width of the mismatch counter.
- `clk` in 1: single clock. All logic is synchronous to the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level or pulse. Sampled only in IDLE and REPORT.
- `isequal` in 1: datapath compare result.
- `max_reg` in 5: datapath most-frequent transition bin.
- `sum_transitions` in 22: datapath total transitions.
- `en_gen_data`, `en_enc`, `en_bus`, `en_dec`, `en_trans_count`, `en_k_comp` out 1 each: stage enables.
- `done` out 1: single-cycle strobe to the datapath.
- `busy` out 1: high from run start to `result_valid`.
- `result_valid` out 1: results stable. Held until the next accepted `start` or reset.
- `pass` out 1: `err_count == 0`. Qualified by `result_valid`.
- `err_count` out `ERR_W`: mismatches seen. Saturates at all-ones.
- `res_max_reg` out 5: captured `max_reg`.
- `res_sum` out 22: captured `sum_transitions`.

## Operation
- States: IDLE, RUN, DRAIN, DONE, CAPTURE, REPORT.
- IDLE: all enables low. `start=1` moves to RUN, clears `err_count`, and clears the word counter.
- RUN: `en_gen_data=1` for exactly `NUM_WORDS` consecutive cycles. The word counter increments per cycle. When the counter reaches `NUM_WORDS-1`, next state is DRAIN.
- Stage enables come from a shift register fed by `en_gen_data`:
  - `en_enc` = tap 1
  - `en_bus` = tap 2
  - `en_dec` and `en_trans_count` = tap 3
  - `en_k_comp` = tap 4
  - check-valid = tap `CHECK_DELAY`
  - Every enable is therefore a contiguous `NUM_WORDS`-cycle window, offset by its tap.
- Check: on each cycle with check-valid=1 and `isequal=0`, `err_count` increments (saturating).
- DRAIN: `en_gen_data=0`. Holds until all shift-register taps are 0, i.e. exactly `CHECK_DELAY` cycles after leaving RUN.
- DONE: `done=1` for exactly one cycle. All enables are 0.
- CAPTURE: one cycle. Latches `max_reg` → `res_max_reg` and `sum_transitions` → `res_sum`; the datapath updates them on the `done` edge.
- REPORT: `result_valid=1`, `busy=0`. `start=1` clears `result_valid`, `err_count` and the counter, and enters RUN on the next cycle.
- `start` during RUN, DRAIN, DONE or CAPTURE is ignored.
- Simultaneous events: a mismatch arriving in the same cycle as the RUN→DRAIN transition is counted. Counting is independent of state.

## Timing
- Reset (`rst=1` at an edge): state IDLE and the shift register is cleared. Every output is 0, including `err_count`, `res_max_reg` and `res_sum`.
- Reset mid-run aborts immediately: all enables are 0 after that edge, and no `done` is issued.
- Latency from accepting `start` (cycle 0):
  - `en_gen_data` high cycles 1..`NUM_WORDS`.
  - `done` at cycle `NUM_WORDS+CHECK_DELAY+1`.
  - `result_valid` first high at cycle `NUM_WORDS+CHECK_DELAY+3`.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle `result_valid` rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `PEECC_CTRL_ERR_STOP_EN`.
- Defined: the first mismatch aborts the run. On the next cycle `en_gen_data` and the entire shift register clear and the FSM enters DONE; `done`, CAPTURE and REPORT follow as normal. In this case `err_count` is 1 and `res_sum` reflects a partial run.
- Undefined: mismatches are only counted and the run always completes all `NUM_WORDS`.

## Test plan
- `NUM_WORDS=8`, `CHECK_DELAY=5`, `isequal` tied 1, `start` pulsed at cycle 0:
  - `en_gen_data` high cycles 1..8, `en_k_comp` high cycles 5..12.
  - `done` only at cycle 14, `result_valid` at 16, `pass=1`, `err_count=0`.
- Same configuration with `isequal=0` during 3 check-valid cycles: `err_count=3`, `pass=0`. With `PEECC_CTRL_ERR_STOP_EN` defined: abort after the first mismatch and `err_count=1`.
- `ERR_W=2`, `isequal` tied 0, `NUM_WORDS=8`: `err_count` saturates at 3.
- Datapath model presents `max_reg=7`, `sum_transitions=22'h0ABCD` after `done`: `res_max_reg=7` and `res_sum=22'h0ABCD` when `result_valid=1`; both hold when the inputs later change.
- `rst=1` at cycle 4 of a run: all outputs 0 next cycle, no `done` pulse. A new `start` then gives a full, correctly timed run.
- `start` held high throughout: runs repeat back-to-back. `start` during RUN has no effect, and `result_valid` clears on re-accept.

Source files
------------

// File: rtl/peecc_run_controller.sv
// rtl/peecc_run_controller.sv - run sequencer for the encode/bus/decode datapath
//
// Purpose:
//   Drives the datapath stage enables for one run of NUM_WORDS generated words,
//   counts isequal mismatches during the check window, pulses done once the
//   pipeline has drained, captures the datapath statistics and holds them as
//   the run result until the next accepted start.
//
// Parameters:
//   NUM_WORDS    words generated per run (1..2047)
//   CHECK_DELAY  cycles from a word's en_gen_data cycle to its isequal cycle
//   ERR_W        width of the saturating mismatch counter
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    run request, sampled only in IDLE and REPORT
//   isequal                  datapath compare result
//   max_reg, sum_transitions datapath statistics, captured after done
//   en_gen_data .. en_k_comp stage enables (registered)
//   done                     single-cycle end-of-run strobe to the datapath
//   busy                     run in progress
//   result_valid, pass       result qualifier and err_count == 0
//   err_count                saturating mismatch count
//   res_max_reg, res_sum     captured statistics
//
// Build option:
//   PEECC_CTRL_ERR_STOP_EN   when defined, the first mismatch aborts the run
//                            and jumps straight to DONE.

module peecc_run_controller #(
    parameter int NUM_WORDS   = 1000,
    parameter int CHECK_DELAY = 5,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isequal,
    input  logic [4:0]       max_reg,
    input  logic [21:0]      sum_transitions,
    output logic             en_gen_data,
    output logic             en_enc,
    output logic             en_bus,
    output logic             en_dec,
    output logic             en_trans_count,
    output logic             en_k_comp,
    output logic             done,
    output logic             busy,
    output logic             result_valid,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       res_max_reg,
    output logic [21:0]      res_sum
);

    // The shift register must be at least four deep to provide the fixed
    // stage taps, and deep enough to reach the check-valid tap.
    localparam int SR_LEN = (CHECK_DELAY > 4) ? CHECK_DELAY : 4;
    localparam logic [10:0] LAST_WORD = 11'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_CAPTURE,
        S_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [10:0]       word_cnt_q, word_cnt_d;
    // sr_q[i] is tap i+1: en_gen_data delayed by i+1 cycles.
    logic [SR_LEN-1:0] sr_q, sr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              en_gen_q, en_gen_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic              pass_q, pass_d;
    logic [4:0]        res_max_q, res_max_d;
    logic [21:0]       res_sum_q, res_sum_d;

    logic              check_valid;
    logic              mismatch;
    logic              accept;

    assign check_valid = sr_q[CHECK_DELAY-1];
    assign mismatch    = check_valid && !isequal;
    assign accept      = ((state_q == S_IDLE) || (state_q == S_REPORT)) && start;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        sr_d       = {sr_q[SR_LEN-2:0], en_gen_q};
        err_d      = err_q;
        res_max_d  = res_max_q;
        res_sum_d  = res_sum_q;

        // Mismatch counting does not depend on the FSM state; only a new
        // run clears the counter.
        if (mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE, S_REPORT: begin
                if (start) begin
                    state_d    = S_RUN;
                    word_cnt_d = '0;
                    err_d      = '0;
                end
            end
            S_RUN: begin
                word_cnt_d = word_cnt_q + 11'd1;
                if (word_cnt_q == LAST_WORD) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the shift register is about to be empty, so the
                // last check-valid cycle is immediately followed by DONE.
                if (sr_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The datapath has updated its statistics on the done edge.
                res_max_d = max_reg;
                res_sum_d = sum_transitions;
                state_d   = S_REPORT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PEECC_CTRL_ERR_STOP_EN
        // First mismatch aborts: flush the pipeline enables and finish the
        // run with a partial result.
        if (mismatch) begin
            state_d = S_DONE;
            sr_d    = '0;
        end
`endif

        // Output flops are loaded from the next state so every output is
        // a register with no input-to-output combinational path.
        en_gen_d = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN) ||
                   (state_d == S_DONE) || (state_d == S_CAPTURE);
        rv_d     = (state_d == S_REPORT);
        pass_d   = (state_d == S_REPORT) && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            sr_q       <= '0;
            err_q      <= '0;
            en_gen_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
            pass_q     <= 1'b0;
            res_max_q  <= '0;
            res_sum_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            sr_q       <= sr_d;
            err_q      <= err_d;
            en_gen_q   <= en_gen_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            rv_q       <= rv_d;
            pass_q     <= pass_d;
            res_max_q  <= res_max_d;
            res_sum_q  <= res_sum_d;
        end
    end

    assign en_gen_data    = en_gen_q;
    assign en_enc         = sr_q[0];
    assign en_bus         = sr_q[1];
    assign en_dec         = sr_q[2];
    assign en_trans_count = sr_q[2];
    assign en_k_comp      = sr_q[3];
    assign done           = done_q;
    assign busy           = busy_q;
    assign result_valid   = rv_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign res_max_reg    = res_max_q;
    assign res_sum        = res_sum_q;

endmodule

// File: tb/tb_peecc_run_controller.sv
// tb/tb_peecc_run_controller.sv - randomized self-checking bench for peecc_run_controller

module tb_peecc_run_controller;

    localparam int N     = 8;
    localparam int CD    = 5;
    localparam int T_DONE = N + CD + 1;
    localparam int T_RV   = N + CD + 3;

    typedef struct {
        int          k;     // cycles since start accepted, 0 = idle
        int          err;
        logic [4:0]  mx;
        logic [21:0] sum;
    } model_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        isequal;
    logic [4:0]  max_reg;
    logic [21:0] sum_transitions;

    logic        en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp;
    logic        done, busy, result_valid, pass;
    logic [15:0] err_count;
    logic [4:0]  res_max_reg;
    logic [21:0] res_sum;

    logic        s_en_gen_data, s_en_enc, s_en_bus, s_en_dec, s_en_trans_count, s_en_k_comp;
    logic        s_done, s_busy, s_result_valid, s_pass;
    logic [1:0]  s_err_count;
    logic [4:0]  s_res_max_reg;
    logic [21:0] s_res_sum;

    int n_checks = 0;
    int n_pass   = 0;

    model_t m;
    model_t ms;

    always #5 clk = ~clk;

    peecc_run_controller #(.NUM_WORDS(N), .CHECK_DELAY(CD), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .isequal(isequal),
        .max_reg(max_reg), .sum_transitions(sum_transitions),
        .en_gen_data(en_gen_data), .en_enc(en_enc), .en_bus(en_bus),
        .en_dec(en_dec), .en_trans_count(en_trans_count), .en_k_comp(en_k_comp),
        .done(done), .busy(busy), .result_valid(result_valid), .pass(pass),
        .err_count(err_count), .res_max_reg(res_max_reg), .res_sum(res_sum)
    );

    // Narrow counter instance with every word mismatching.
    peecc_run_controller #(.NUM_WORDS(N), .CHECK_DELAY(CD), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .isequal(1'b0),
        .max_reg(max_reg), .sum_transitions(sum_transitions),
        .en_gen_data(s_en_gen_data), .en_enc(s_en_enc), .en_bus(s_en_bus),
        .en_dec(s_en_dec), .en_trans_count(s_en_trans_count), .en_k_comp(s_en_k_comp),
        .done(s_done), .busy(s_busy), .result_valid(s_result_valid), .pass(s_pass),
        .err_count(s_err_count), .res_max_reg(s_res_max_reg), .res_sum(s_res_sum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Timeline model: a run is a count of cycles since acceptance; every
    // output is a window on that count.
    task automatic model_step(inout model_t md, input bit rst_i, input bit start_i,
                              input bit iseq_i, input logic [4:0] mx_i,
                              input logic [21:0] sum_i, input int err_max);
        bit miss;
        if (rst_i) begin
            md.k = 0; md.err = 0; md.mx = '0; md.sum = '0;
        end else if ((md.k == 0 || md.k >= T_RV) && start_i) begin
            md.k = 1; md.err = 0;
        end else if (md.k != 0 && md.k < T_RV) begin
            miss = (md.k >= CD + 1) && (md.k <= N + CD) && !iseq_i;
            if (miss && md.err < err_max) md.err++;
            if (md.k == T_DONE + 1) begin
                md.mx = mx_i; md.sum = sum_i;
            end
`ifdef PEECC_CTRL_ERR_STOP_EN
            if (miss) md.k = T_DONE;
            else md.k++;
`else
            md.k++;
`endif
        end
    endtask

    task automatic check_all();
        int k;
        k = m.k;
        check("en_gen_data", en_gen_data, k >= 1 && k <= N);
        check("en_enc", en_enc, k >= 2 && k <= N + 1);
        check("en_bus", en_bus, k >= 3 && k <= N + 2);
        check("en_dec", en_dec, k >= 4 && k <= N + 3);
        check("en_trans_count", en_trans_count, k >= 4 && k <= N + 3);
        check("en_k_comp", en_k_comp, k >= 5 && k <= N + 4);
        check("done", done, k == T_DONE);
        check("busy", busy, k >= 1 && k < T_RV);
        check("result_valid", result_valid, k >= T_RV);
        check("pass", pass, k >= T_RV && m.err == 0);
        check("err_count", err_count, m.err);
        check("res_max_reg", res_max_reg, m.mx);
        check("res_sum", res_sum, m.sum);
        check("sat_err_count", s_err_count, ms.err);
        check("sat_result_valid", s_result_valid, ms.k >= T_RV);
        check("sat_done", s_done, ms.k == T_DONE);
    endtask

    // {start %, mismatch %, reset per-mille, cycles}
    int seg [6][4] = '{
        '{5,   0,  0, 200},
        '{5,   3,  0, 300},
        '{5,  30,  0, 200},
        '{100, 2,  0, 200},
        '{10,  3, 15, 400},
        '{3,  50,  0, 200}
    };

    initial begin
        m  = '{0, 0, '0, '0};
        ms = '{0, 0, '0, '0};
        rst = 1'b1; start = 1'b0; isequal = 1'b1;
        max_reg = '0; sum_transitions = '0;
        @(posedge clk);
        model_step(m, 1'b1, 1'b0, 1'b1, '0, '0, 65535);
        model_step(ms, 1'b1, 1'b0, 1'b0, '0, '0, 3);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < seg[s][3]; c++) begin
                start           = ($urandom_range(99) < seg[s][0]);
                isequal         = ($urandom_range(99) >= seg[s][1]);
                rst             = ($urandom_range(999) < seg[s][2]);
                max_reg         = 5'($urandom);
                sum_transitions = 22'($urandom);
                @(posedge clk);
                model_step(m, rst, start, isequal, max_reg, sum_transitions, 65535);
                model_step(ms, rst, start, 1'b0, max_reg, sum_transitions, 3);
                @(negedge clk);
                check_all();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
